// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first.
//
// The serial input is synchronised with two flops. A falling edge on the line
// starts a frame. The start bit is re-checked half a bit period later, which
// rejects short glitches. Each data bit and the stop bit are then sampled one
// full bit period apart, so every sample lands near the middle of its bit.
//
// Parameters:
//   CLKDIV     clk cycles per bit; must be even and >= 4
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   rx         serial line, asynchronous to clk, idles high
//   data       last correctly framed byte, held between frames
//   valid      one-cycle strobe, high in the first cycle data shows a new byte
//   frame_err  one-cycle strobe, high when the stop bit was sampled low
//   busy       high whenever the receiver is not idle
module uart_rx #(
    parameter int unsigned CLKDIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CntW = $clog2(CLKDIV);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKDIV / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKDIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e          state;
    logic            rx_meta;
    logic            rx_s;
    logic [CntW-1:0] cnt;
    logic [2:0]      bitidx;
    logic [7:0]      shreg;

    // Two-flop synchroniser. Both flops reset to the idle level so that a
    // reset never produces a false start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            cnt       <= '0;
            bitidx    <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                StIdle: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= StStart;
                        busy  <= 1'b1;
                    end
                end
                StStart: begin
                    if (cnt == HalfLast) begin
                        cnt <= '0;
                        if (rx_s) begin
                            // Line went high again before mid start bit: glitch.
                            state <= StIdle;
                            busy  <= 1'b0;
                        end else begin
                            state  <= StData;
                            bitidx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StData: begin
                    if (cnt == BitLast) begin
                        cnt    <= '0;
                        shreg  <= {rx_s, shreg[7:1]};
                        bitidx <= bitidx + 1'b1;
                        if (bitidx == 3'd7) begin
                            state <= StStop;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt == BitLast) begin
                        cnt <= '0;
                        if (rx_s) begin
                            // Leaving mid stop bit lets a back-to-back start bit be seen.
                            data  <= shreg;
                            valid <= 1'b1;
                            state <= StIdle;
                            busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= StBreak;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StBreak: begin
                    // A held-low line must not be mistaken for a new start bit.
                    cnt <= '0;
                    if (rx_s) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomised frames into two receivers (CLKDIV 16 and 4).
// Expected bytes and valid timing come from the frame rules: a good frame yields
// its byte 9*CLKDIV + CLKDIV/2 + 2 edges after the edge that first sees the start bit.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx16;
    logic       rx4;
    logic [7:0] data16;
    logic       valid16;
    logic       frame_err16;
    logic       busy16;
    logic [7:0] data4;
    logic       valid4;
    logic       frame_err4;
    logic       busy4;

    always #5 clk = ~clk;

    uart_rx #(.CLKDIV(16)) dut16 (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx16),
        .data      (data16),
        .valid     (valid16),
        .frame_err (frame_err16),
        .busy      (busy16)
    );

    uart_rx #(.CLKDIV(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx4),
        .data      (data4),
        .valid     (valid4),
        .frame_err (frame_err4),
        .busy      (busy4)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation log, sampled on the falling edge.
    logic [7:0] got16[$];
    int         cyc16[$];
    logic [7:0] got4[$];
    int         cyc4[$];
    int         ferr16_cnt = 0;
    int         ferr4_cnt = 0;
    int         busy16_cnt = 0;
    int         pulse_bad = 0;
    logic       prev16 = 1'b0;
    logic       prev4 = 1'b0;

    always @(negedge clk) begin
        if (valid16) begin
            got16.push_back(data16);
            cyc16.push_back(cyc);
        end
        if (valid4) begin
            got4.push_back(data4);
            cyc4.push_back(cyc);
        end
        if (frame_err16) ferr16_cnt++;
        if (frame_err4) ferr4_cnt++;
        if (busy16) busy16_cnt++;
        if ((valid16 && frame_err16) || ((valid16 || frame_err16) && prev16)) pulse_bad++;
        if ((valid4 && frame_err4) || ((valid4 || frame_err4) && prev4)) pulse_bad++;
        prev16 = valid16 || frame_err16;
        prev4  = valid4 || frame_err4;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int latency(input int div);
        return 9 * div + div / 2 + 2;
    endfunction

    function automatic int got_at(input bit four, input int k);
        if (four) return (k < got4.size()) ? int'(got4[k]) : -1;
        return (k < got16.size()) ? int'(got16[k]) : -1;
    endfunction

    function automatic int cyc_at(input bit four, input int k);
        if (four) return (k < cyc4.size()) ? cyc4[k] : -1;
        return (k < cyc16.size()) ? cyc16[k] : -1;
    endfunction

    // All line-driving tasks are entered and left just after a falling edge.
    task automatic hold(input bit four, input logic v, input int n);
        if (four) rx4 = v;
        else rx16 = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input bit four, input logic [7:0] b, input logic stop, output int e0);
        int div;
        div = four ? 4 : 16;
        e0 = cyc + 1;  // next rising edge is the first to capture the start bit
        hold(four, 1'b0, div);
        for (int i = 0; i < 8; i++) hold(four, b[i], div);
        hold(four, stop, div);
    endtask

    initial begin
        logic [7:0] exp16[$];
        int         e016[$];
        logic [7:0] exp4[$];
        int         e04[$];
        logic [7:0] last16;
        logic [7:0] b;
        int         e0;
        int         ferr_before;
        int         busy_before;
        int         nval_before;

        reset = 1'b1;
        rx16  = 1'b1;
        rx4   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data16", int'(data16), 8'h00);
        check("reset_valid16", int'(valid16), 0);
        check("reset_ferr16", int'(frame_err16), 0);
        check("reset_busy16", int'(busy16), 0);
        check("reset_data4", int'(data4), 8'h00);
        check("reset_busy4", int'(busy4), 0);
        reset = 1'b0;
        hold(1'b0, 1'b1, 5);

        // Single byte 0x5C.
        send(1'b0, 8'h5C, 1'b1, e0);
        exp16.push_back(8'h5C);
        e016.push_back(e0);
        hold(1'b0, 1'b1, 20);
        check("single_count", got16.size(), 1);
        check("single_data", got_at(1'b0, 0), 8'h5C);
        check("single_latency", cyc_at(1'b0, 0) - e0, 154);
        check("single_ferr", ferr16_cnt, 0);

        // Transmitter-style stream: incrementing bytes, first back-to-back then
        // random idle gaps.
        for (int k = 0; k < 8; k++) begin
            b = 8'h5C + 8'(k);
            send(1'b0, b, 1'b1, e0);
            exp16.push_back(b);
            e016.push_back(e0);
            if (k >= 4) hold(1'b0, 1'b1, $urandom_range(0, 40));
        end
        // Random bytes with random gaps.
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            send(1'b0, b, 1'b1, e0);
            exp16.push_back(b);
            e016.push_back(e0);
            hold(1'b0, 1'b1, $urandom_range(0, 24));
        end
        hold(1'b0, 1'b1, 20);
        check("stream_count", got16.size(), exp16.size());
        for (int k = 1; k < exp16.size(); k++) begin
            check($sformatf("stream_data[%0d]", k), got_at(1'b0, k), int'(exp16[k]));
            check($sformatf("stream_latency[%0d]", k), cyc_at(1'b0, k) - e016[k], latency(16));
        end
        check("stream_ferr", ferr16_cnt, 0);

        // Glitch: 4 clk low, then high.
        busy_before = busy16_cnt;
        nval_before = got16.size();
        hold(1'b0, 1'b0, 4);
        hold(1'b0, 1'b1, 30);
        check("glitch_busy_cycles", busy16_cnt - busy_before, 16 / 2);
        check("glitch_no_valid", got16.size(), nval_before);
        check("glitch_no_ferr", ferr16_cnt, 0);
        check("glitch_idle", int'(busy16), 0);
        send(1'b0, 8'hA5, 1'b1, e0);
        exp16.push_back(8'hA5);
        e016.push_back(e0);
        hold(1'b0, 1'b1, 20);
        check("glitch_next_count", got16.size(), exp16.size());
        check("glitch_next_data", got_at(1'b0, exp16.size() - 1), 8'hA5);
        check("glitch_next_latency", cyc_at(1'b0, exp16.size() - 1) - e0, latency(16));
        last16 = 8'hA5;

        // Framing error: stop bit low, line held low 40 more clk.
        ferr_before = ferr16_cnt;
        nval_before = got16.size();
        send(1'b0, 8'h3C, 1'b0, e0);
        hold(1'b0, 1'b0, 40);
        check("ferr_pulse", ferr16_cnt - ferr_before, 1);
        check("ferr_no_valid", got16.size(), nval_before);
        check("ferr_data_held", int'(data16), int'(last16));
        check("ferr_busy_in_break", int'(busy16), 1);
        hold(1'b0, 1'b1, 4);
        check("ferr_busy_released", int'(busy16), 0);
        hold(1'b0, 1'b1, 10);
        send(1'b0, 8'h81, 1'b1, e0);
        exp16.push_back(8'h81);
        e016.push_back(e0);
        hold(1'b0, 1'b1, 20);
        check("ferr_next_count", got16.size(), exp16.size());
        check("ferr_next_data", got_at(1'b0, exp16.size() - 1), 8'h81);
        check("ferr_total", ferr16_cnt - ferr_before, 1);

        // Reset during data bit 4 of 0xFF.
        nval_before = got16.size();
        hold(1'b0, 1'b0, 16);
        for (int i = 0; i < 4; i++) hold(1'b0, 1'b1, 16);
        hold(1'b0, 1'b1, 6);
        reset = 1'b1;
        @(negedge clk);
        check("rst_data", int'(data16), 8'h00);
        check("rst_busy", int'(busy16), 0);
        check("rst_valid", int'(valid16), 0);
        check("rst_ferr", int'(frame_err16), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hold(1'b0, 1'b1, 200);
        check("rst_no_valid", got16.size(), nval_before);
        check("rst_data_after", int'(data16), 8'h00);
        send(1'b0, 8'h12, 1'b1, e0);
        exp16.push_back(8'h12);
        e016.push_back(e0);
        hold(1'b0, 1'b1, 20);
        check("rst_next_count", got16.size(), exp16.size());
        check("rst_next_data", got_at(1'b0, exp16.size() - 1), 8'h12);
        check("rst_next_latency", cyc_at(1'b0, exp16.size() - 1) - e0, latency(16));

        // CLKDIV=4: 0x00 then 0xFF back-to-back, then random back-to-back bytes.
        hold(1'b1, 1'b1, 5);
        send(1'b1, 8'h00, 1'b1, e0);
        exp4.push_back(8'h00);
        e04.push_back(e0);
        send(1'b1, 8'hFF, 1'b1, e0);
        exp4.push_back(8'hFF);
        e04.push_back(e0);
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            send(1'b1, b, 1'b1, e0);
            exp4.push_back(b);
            e04.push_back(e0);
        end
        hold(1'b1, 1'b1, 20);
        check("div4_count", got4.size(), exp4.size());
        check("div4_first_latency", cyc_at(1'b1, 0) - e04[0], 40);
        for (int k = 0; k < exp4.size(); k++) begin
            check($sformatf("div4_data[%0d]", k), got_at(1'b1, k), int'(exp4[k]));
            check($sformatf("div4_latency[%0d]", k), cyc_at(1'b1, k) - e04[k], latency(4));
        end
        check("div4_ferr", ferr4_cnt, 0);

        check("pulse_rules", pulse_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
